lsu_mem_adapter: RTL and testbench

Load/store unit sitting directly upstream of memory_sim, between the core's execute stage and the word-addressed memory.
- Accepts one byte, halfword or word load/store request at a time.
- Drives word-aligned memory accesses.
- Implements sub-word stores as read-modify-write, because the memory has no byte enables.
- Returns sign- or zero-extended load data as a single-cycle response.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_mem_adapter.sv | 126 ++++++++++++
 tb/tb_lsu_mem_adapter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states, request record and width-code checks
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > SW;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct3[1:0] encodes the access size for every legal load and store
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads, lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // halfword lane uses addr[1] only, so a misaligned halfword is aligned down
  always_comb begin
    lane_b     = word[{addr, 3'b000} +: 8];
    lane_h     = addr[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_word = wdata;
    case (funct3)
      LB:      load_data = {{24{lane_b[7]}}, lane_b};
      LH:      load_data = {{16{lane_h[15]}}, lane_h};
      LBU:     load_data = {24'd0, lane_b};
      LHU:     load_data = {16'd0, lane_h};
      default: load_data = word;
    endcase
    if (funct3 == SB) begin
      store_word = word;
      store_word[{addr, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == SH) begin
      store_word = word;
      if (addr[1]) store_word[31:16] = wdata[15:0];
      else         store_word[15:0]  = wdata[15:0];
    end
    misaligned = f3_misaligned(funct3, addr);
    illegal    = f3_illegal(we, funct3);
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - byte/half/word load-store adapter onto word memory with RMW sub-word stores
// LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error instead of aligning down.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_t       state, state_n;
  lsu_req_t         req_q;
  logic             err_q;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] word_q;

  logic             idle, req_err;
  logic             a_we;
  logic [2:0]       a_funct3;
  logic [1:0]       a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic [WIDTH-1:0] load_data, store_word;
  logic             misaligned, illegal;

  // while idle the checker looks at the incoming request, otherwise at the latched one
  assign idle     = (state == IDLE);
  assign a_we     = idle ? req_we         : req_q.we;
  assign a_funct3 = idle ? req_funct3     : req_q.funct3;
  assign a_addr   = idle ? req_addr[1:0]  : req_q.addr[1:0];
  assign a_wdata  = idle ? req_wdata      : req_q.wdata;

  lsu_align u_align (
    .we         (a_we),
    .funct3     (a_funct3),
    .addr       (a_addr),
    .word       (word_q),
    .wdata      (a_wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = illegal | misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign req_err = illegal;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      req_q  <= '0;
      err_q  <= 1'b0;
      cnt    <= 8'd0;
      word_q <= '0;
    end else begin
      state <= state_n;
      if (idle && req_valid) begin
        req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
        err_q <= req_err;
        cnt   <= 8'(MEM_RD_LAT);
      end
      if (state == READ) begin
        if (cnt == 8'd0) word_q <= mem_rdata;
        else             cnt    <= cnt - 8'd1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                         state_n = RESP;
          else if (req_we && req_funct3 == SW) state_n = WRITE;
          else                                 state_n = READ;
        end
      end
      READ: begin
        mem_addr = {req_q.addr[WIDTH-1:2], 2'b00};
        if (cnt == 8'd0) state_n = req_q.we ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr  = {req_q.addr[WIDTH-1:2], 2'b00};
        mem_wdata = store_word;
        mem_we    = 1'b1;
        state_n   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!req_q.we && !err_q) resp_rdata = load_data;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb/tb_lsu_mem_adapter.sv - directed and randomized checks of lsu_mem_adapter against a byte-lane memory model
module tb_lsu_mem_adapter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int checks = 0;
  int errors = 0;

  lsu_mem_adapter #(.WIDTH(32), .MEM_RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // memory with one cycle of read latency and no byte enables
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_rvalid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_rdata"},  resp_rdata,          32'd0);
    check({tag, "_rerr"},   {31'd0, resp_err},   32'd0);
    check({tag, "_maddr"},  mem_addr,            32'd0);
    check({tag, "_mwdata"}, mem_wdata,           32'd0);
    check({tag, "_mwe"},    {31'd0, mem_we},     32'd0);
  endtask

  // One request: model predicts from the byte-lane rules, DUT is observed cycle by cycle.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold, output logic [31:0] rdata_obs);
    int unsigned size, off, widx;
    logic [31:0] mask, w, e_rdata, e_word;
    bit          e_err, illegal;
    int          e_resp, e_we_cycle, e_we_cnt;
    int          resp_cycle, we_cycle, we_cnt;
    logic [31:0] we_addr, we_data, rd_addr, o_err;
    logic        ready1;

    size    = 1 << f3[1:0];
    widx    = addr[7:2];
    w       = ref_mem[widx];
    illegal = we ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
`ifdef LSU_MISALIGN_TRAP_EN
    e_err = illegal || (addr % size != 0);
`else
    e_err = illegal;
`endif
    off     = (addr % 4) - ((addr % 4) % size);
    mask    = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    e_rdata = 32'd0;
    e_word  = w;
    if (!e_err && !we) begin
      e_rdata = (w >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && e_rdata[8*size-1]) e_rdata = e_rdata | ~mask;
    end
    if (!e_err && we)
      e_word = (size == 4) ? wdata : ((w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off)));
    e_resp     = e_err ? 1 : (!we ? 2 + LAT : (size == 4 ? 2 : 3 + LAT));
    e_we_cycle = (size == 4) ? 1 : 2 + LAT;
    e_we_cnt   = (!e_err && we) ? 1 : 0;

    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;

    resp_cycle = 0; we_cycle = 0; we_cnt = 0;
    we_addr = 32'd0; we_data = 32'd0; rd_addr = 32'd0; o_err = 32'd0; ready1 = 1'b1;
    rdata_obs = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ready1  = req_ready;
        rd_addr = mem_addr;
      end
      if (mem_we) begin
        we_cnt++;
        we_cycle = c;
        we_addr  = mem_addr;
        we_data  = mem_wdata;
      end
      if (resp_valid) begin
        resp_cycle = c;
        o_err      = {31'd0, resp_err};
        rdata_obs  = resp_rdata;
        req_valid  = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;

    check("resp_cycle", resp_cycle, e_resp);
    check("resp_err",   o_err, {31'd0, e_err});
    check("resp_rdata", rdata_obs, e_rdata);
    check("we_count",   we_cnt, e_we_cnt);
    check("busy_ready", {31'd0, ready1}, 32'd0);
    check("first_addr", rd_addr, e_err ? 32'd0 : {addr[31:2], 2'b00});
    if (e_we_cnt == 1) begin
      check("we_cycle", we_cycle, e_we_cycle);
      check("we_addr",  we_addr, {addr[31:2], 2'b00});
      check("we_data",  we_data, e_word);
    end
    ref_mem[widx] = e_word;
  endtask

  initial begin
    logic [31:0] r;
    int          we_seen, rv_seen;

    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // word 0x4 = 0xCAFEBABE
    run_req(1'b1, 3'b010, 32'h4, 32'hCAFEBABE, 1'b0, r);
    run_req(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, r);
    check("t1_lb", r, 32'hFFFF_FFCA);
    run_req(1'b0, 3'b101, 32'h4, 32'h0, 1'b0, r);
    check("t2_lhu", r, 32'h0000_BABE);
    run_req(1'b0, 3'b001, 32'h6, 32'h0, 1'b1, r);
    check("t2_lh", r, 32'hFFFF_CAFE);
    run_req(1'b1, 3'b000, 32'h5, 32'h11, 1'b0, r);
    check("t3_mem", mem[1], 32'hCAFE_11BE);
    run_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, r);
    check("t3_lw", r, 32'hCAFE_11BE);
    run_req(1'b1, 3'b010, 32'h8, 32'h12345678, 1'b0, r);
    run_req(1'b0, 3'b010, 32'h6, 32'h0, 1'b0, r);
`ifndef LSU_MISALIGN_TRAP_EN
    check("t5_lw_aligned", r, 32'hCAFE_11BE);
`endif
    // illegal width codes
    run_req(1'b0, 3'b011, 32'h4, 32'h0, 1'b0, r);
    run_req(1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF, 1'b0, r);

    // reset in the middle of an SH read
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    we_seen = 0; rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (resp_valid) rv_seen++;
    end
    check("midrst_no_we", we_seen, 0);
    check("midrst_no_resp", rv_seen, 0);
    rst = 1'b1;
    run_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, r);
    run_req(1'b1, 3'b001, 32'h22, 32'hBEEF, 1'b0, r);
    run_req(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, r);
    check("t6_after", r, 32'h0000_BEEF);

    for (int i = 0; i < 60; i++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
              $urandom, 1'($urandom_range(0, 1)), r);
    end
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
